dmem_responder: RTL and testbench

Data-memory responder for the small RISC-V core: the slave end of the `mem_in_type`/`mem_out_type` handshake that the execute stage drives for loads and stores. It accepts one word-wide request at a time and models a configurable number of wait states. It commits byte-masked writes into an internal SRAM, returns full read words for the LSU to extract, and completes out-of-range accesses with an error pulse so the pipeline never hangs.

---
 rtl/dmem_responder_pkg.sv | 59 +++++
 rtl/dmem_responder_sram.sv | 35 +++
 rtl/dmem_responder.sv | 122 ++++++++++++
 tb/tb_dmem_responder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared memory-bus types plus the data-memory responder's register record.
// Both dmem_responder and its SRAM import this package.
package wires;

    typedef struct packed {
        logic        mem_valid;
        logic        mem_instr;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic [31:0] mem_rdata;
    } mem_out_type;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_type;

    typedef struct packed {
        dmem_state_type state;
        logic [3:0]     cnt;
        logic [31:0]    addr;
        logic [31:0]    wdata;
        logic [3:0]     wstrb;
        logic           inrange;
        logic           ready;
        logic [31:0]    rdata;
        logic           err;
    } dmem_reg_type;

    localparam dmem_reg_type init_dmem_reg = '{
        state:   IDLE,
        cnt:     4'd0,
        addr:    32'd0,
        wdata:   32'd0,
        wstrb:   4'd0,
        inrange: 1'b0,
        ready:   1'b0,
        rdata:   32'd0,
        err:     1'b0
    };

    // 33-bit compare so a window ending at 2^32 does not wrap to zero.
    function automatic logic dmem_in_range(input logic [31:0] addr,
                                           input logic [31:0] base,
                                           input int unsigned depth);
        logic [32:0] lo;
        logic [32:0] hi;
        lo = {1'b0, base};
        hi = lo + 33'(depth) * 33'd4;
        return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
    endfunction

endpackage

// File: rtl/dmem_responder_sram.sv
// Single-port, byte-writable, synchronous-read RAM (read-first).
// Each byte lane is its own array so the tools infer lane write enables.
module dmem_sram
    import wires::*;
#(
    parameter int DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    wstrb,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] mem [DEPTH_WORDS];
            logic [7:0] q_reg;

            always_ff @(posedge clk) begin
                if (en) begin
                    if (wstrb[gi]) begin
                        mem[addr] <= wdata[gi*8 +: 8];
                    end
                    q_reg <= mem[addr];
                end
            end

            assign rdata[gi*8 +: 8] = q_reg;
        end
    endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory slave for the execute stage: one request at a time, fixed wait
// states, byte-masked writes into dmem_sram, error pulse for out-of-range.
module dmem_responder
    import wires::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    dmem_reg_type r;
    dmem_reg_type rin;

    logic          sram_en;
    logic [3:0]    sram_wstrb;
    logic [AW-1:0] sram_addr;
    logic [31:0]   sram_rdata;
    logic [31:0]   resp_rdata;
    logic          unused_ok;

    function automatic logic [AW-1:0] word_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE_ADDR;
        return off[AW+1:2];
    endfunction

    assign unused_ok = &{1'b0, dmem_in.mem_instr};

    // Out-of-range responses return zero regardless of what the RAM read.
    assign resp_rdata = r.inrange ? sram_rdata : 32'd0;

    always_comb begin
        dmem_reg_type v;
        v          = r;
        v.ready    = 1'b0;
        v.err      = 1'b0;
        sram_en    = 1'b0;
        sram_wstrb = 4'd0;
        sram_addr  = word_index(r.addr);

        if (r.state == RESP) begin
            v.rdata = resp_rdata;
        end

        case (r.state)
            IDLE: begin
                if (dmem_in.mem_valid) begin
                    v.addr    = dmem_in.mem_addr;
                    v.wdata   = dmem_in.mem_wdata;
                    v.wstrb   = dmem_in.mem_wstrb;
                    v.inrange = dmem_in_range(dmem_in.mem_addr, BASE_ADDR, DEPTH_WORDS);
                    v.cnt     = 4'(WAIT_STATES);
                    if (WAIT_STATES > 0) begin
                        v.state = WAIT;
                    end else begin
                        // No wait states: read straight from the request so data lands in RESP.
                        v.state   = RESP;
                        v.ready   = 1'b1;
                        v.err     = !v.inrange;
                        sram_en   = 1'b1;
                        sram_addr = word_index(dmem_in.mem_addr);
                    end
                end
            end
            WAIT: begin
                v.cnt = r.cnt - 4'd1;
                if (r.cnt == 4'd1) begin
                    v.state = RESP;
                    v.ready = 1'b1;
                    v.err   = !r.inrange;
                    sram_en = 1'b1;
                end
            end
            RESP: begin
                v.state = IDLE;
                if (r.inrange && (r.wstrb != 4'd0)) begin
                    sram_en    = 1'b1;
                    sram_wstrb = r.wstrb;
                end
            end
            default: begin
                v.state = IDLE;
            end
        endcase

        if (!rst) begin
            v          = init_dmem_reg;
            sram_en    = 1'b0;
            sram_wstrb = 4'd0;
        end

        rin = v;
    end

    always_ff @(posedge clk) begin
        r <= rin;
    end

    dmem_sram #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .wstrb (sram_wstrb),
        .addr  (sram_addr),
        .wdata (r.wdata),
        .rdata (sram_rdata)
    );

    assign dmem_out.mem_ready = r.ready;
    assign dmem_out.mem_rdata = r.ready ? resp_rdata : r.rdata;
    assign err                = r.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances (WAIT_STATES 1, 0, 5)
// share clock and reset; expected responses are queued at issue time.
module tb_dmem_responder;
    import wires::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_in_type  din  [3];
    mem_out_type dout [3];
    logic        derr [3];

    int ws [3] = '{1, 0, 5};

    dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(1)) u_dut_ws1 (
        .clk(clk), .rst(rst), .dmem_in(din[0]), .dmem_out(dout[0]), .err(derr[0]));
    dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(0)) u_dut_ws0 (
        .clk(clk), .rst(rst), .dmem_in(din[1]), .dmem_out(dout[1]), .err(derr[1]));
    dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0000_1000), .WAIT_STATES(5)) u_dut_ws5 (
        .clk(clk), .rst(rst), .dmem_in(din[2]), .dmem_out(dout[2]), .err(derr[2]));

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic        err;
        logic        chk_rd;
    } exp_t;

    exp_t        sb [$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          last_ready [3];
    logic [31:0] held [3];
    logic        held_ok [3];

    always @(posedge clk) cyc <= cyc + 1;

    // Drive a request now, wait for ready, check latency/data/err against the queued expectation.
    task automatic run_txn(input int d, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input logic [31:0] exp_rd,
                           input logic exp_err, input logic b2b, input string name);
        exp_t e;
        int   k;
        int   exp_k;
        logic seen;
        din[d].mem_valid = 1'b1;
        din[d].mem_instr = 1'b0;
        din[d].mem_addr  = addr;
        din[d].mem_wdata = wdata;
        din[d].mem_wstrb = wstrb;
        e.d      = d;
        e.rdata  = exp_rd;
        e.err    = exp_err;
        e.chk_rd = exp_err || (wstrb == 4'd0);
        sb.push_back(e);
        exp_k = ws[d] + 1 + (b2b ? 1 : 0);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            if (dout[d].mem_ready === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s dut%0d timeout: no ready after %0d cycles, required ready after %0d", name, d, k, exp_k);
            din[d].mem_valid = 1'b0;
            return;
        end
        total++;
        if (k !== exp_k) begin
            bad++;
            $display("FAIL %s dut%0d latency: got %0d cycles, required %0d", name, d, k, exp_k);
        end
        if (b2b) begin
            total++;
            if (cyc - last_ready[d] !== ws[d] + 2) begin
                bad++;
                $display("FAIL %s dut%0d spacing: got %0d cycles, required %0d", name, d, cyc - last_ready[d], ws[d] + 2);
            end
        end
        last_ready[d] = cyc;
        total++;
        if (derr[e.d] !== e.err) begin
            bad++;
            $display("FAIL %s dut%0d err: got %b, required %b", name, d, derr[d], e.err);
        end
        if (e.chk_rd) begin
            total++;
            if (dout[e.d].mem_rdata !== e.rdata) begin
                bad++;
                $display("FAIL %s dut%0d rdata: got %h, required %h", name, d, dout[d].mem_rdata, e.rdata);
            end
            held[d]    = e.rdata;
            held_ok[d] = 1'b1;
        end else begin
            held_ok[d] = 1'b0;
        end
        $display("txn %s dut%0d addr=%h wstrb=%h rdata=%h err=%b lat=%0d", name, d, addr, wstrb,
                 dout[d].mem_rdata, derr[d], k);
    endtask

    // Drop the request and confirm ready/err were single-cycle and rdata holds.
    task automatic idle(input int d, input string name);
        din[d].mem_valid = 1'b0;
        din[d].mem_wstrb = 4'd0;
        @(posedge clk);
        #1;
        total++;
        if (dout[d].mem_ready !== 1'b0 || derr[d] !== 1'b0) begin
            bad++;
            $display("FAIL %s dut%0d pulse: got ready=%b err=%b, required 0 0", name, d, dout[d].mem_ready, derr[d]);
        end
        if (held_ok[d]) begin
            total++;
            if (dout[d].mem_rdata !== held[d]) begin
                bad++;
                $display("FAIL %s dut%0d hold: got rdata=%h, required %h", name, d, dout[d].mem_rdata, held[d]);
            end
        end
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        din[0].mem_valid = 1'b1;
        din[0].mem_addr  = 32'h0000_0400;
        din[0].mem_wstrb = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (dout[0].mem_ready !== 1'b0 || dout[0].mem_rdata !== 32'd0 || derr[0] !== 1'b0) begin
                bad++;
                $display("FAIL reset_hold cycle %0d: got ready=%b rdata=%h err=%b, required 0 00000000 0",
                         i, dout[0].mem_ready, dout[0].mem_rdata, derr[0]);
            end
        end
        rst = 1'b1;
        run_txn(0, 32'h0000_0400, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, "reset_release");
        idle(0, "reset_release");
    endtask

    task automatic test_write_read();
        run_txn(0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'd0, 1'b0, 1'b0, "full_write");
        idle(0, "full_write");
        run_txn(0, 32'h0000_0010, 32'd0, 4'd0, 32'hDEAD_BEEF, 1'b0, 1'b0, "full_read");
        idle(0, "full_read");
    endtask

    task automatic test_byte_lane();
        run_txn(0, 32'h0000_0010, 32'h1122_3344, 4'b0100, 32'd0, 1'b0, 1'b0, "lane_write");
        run_txn(0, 32'h0000_0013, 32'd0, 4'd0, 32'hDE22_BEEF, 1'b0, 1'b1, "lane_read");
        idle(0, "lane_read");
    endtask

    task automatic test_out_of_range();
        run_txn(0, 32'h0000_0000, 32'h0123_4567, 4'hF, 32'd0, 1'b0, 1'b0, "oor_setup");
        idle(0, "oor_setup");
        run_txn(0, 32'h0000_0400, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, "oor_read");
        idle(0, "oor_read");
        run_txn(0, 32'h0000_0400, 32'h5555_5555, 4'hF, 32'd0, 1'b1, 1'b0, "oor_write");
        idle(0, "oor_write");
        run_txn(0, 32'h0000_0000, 32'd0, 4'd0, 32'h0123_4567, 1'b0, 1'b0, "oor_word0");
        idle(0, "oor_word0");
        run_txn(0, 32'hFFFF_FFFC, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, "oor_top");
        idle(0, "oor_top");
        run_txn(1, 32'h0000_0FFC, 32'd0, 4'd0, 32'd0, 1'b1, 1'b0, "oor_below_base");
        idle(1, "oor_below_base");
        run_txn(1, 32'h0000_13FC, 32'hCAFE_F00D, 4'hF, 32'd0, 1'b0, 1'b0, "last_word_wr");
        run_txn(1, 32'h0000_13FC, 32'd0, 4'd0, 32'hCAFE_F00D, 1'b0, 1'b1, "last_word_rd");
        run_txn(1, 32'h0000_1400, 32'd0, 4'd0, 32'd0, 1'b1, 1'b1, "oor_end");
        idle(1, "oor_end");
    endtask

    task automatic test_back_to_back();
        logic [31:0] base;
        for (int d = 0; d < 3; d++) begin
            base = (d == 0) ? 32'h0000_0080 : 32'h0000_1080;
            for (int i = 0; i < 4; i++) begin
                run_txn(d, base + 32'(4 * i), 32'hC0DE_0000 + 32'(i * 32'h1111) + 32'(d << 8),
                        4'hF, 32'd0, 1'b0, (i > 0), "sweep_wr");
            end
            idle(d, "sweep_wr");
            for (int i = 0; i < 4; i++) begin
                run_txn(d, base + 32'(4 * i), 32'd0, 4'd0,
                        32'hC0DE_0000 + 32'(i * 32'h1111) + 32'(d << 8), 1'b0, (i > 0), "sweep_rd");
            end
            idle(d, "sweep_rd");
        end
    endtask

    task automatic test_reset_mid_write();
        logic stray;
        run_txn(0, 32'h0000_0020, 32'h0000_0000, 4'hF, 32'd0, 1'b0, 1'b0, "mid_clear");
        idle(0, "mid_clear");
        din[0].mem_valid = 1'b1;
        din[0].mem_addr  = 32'h0000_0020;
        din[0].mem_wdata = 32'hAAAA_AAAA;
        din[0].mem_wstrb = 4'hF;
        @(posedge clk);
        #1;
        rst = 1'b0;
        din[0].mem_valid = 1'b0;
        din[0].mem_wstrb = 4'd0;
        @(posedge clk);
        #1;
        total++;
        if (dout[0].mem_ready !== 1'b0 || dout[0].mem_rdata !== 32'd0 || derr[0] !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: got ready=%b rdata=%h err=%b, required 0 00000000 0",
                     dout[0].mem_ready, dout[0].mem_rdata, derr[0]);
        end
        rst = 1'b1;
        for (int d = 0; d < 3; d++) begin
            held[d]    = 32'd0;
            held_ok[d] = 1'b1;
        end
        stray = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (dout[0].mem_ready !== 1'b0) stray = 1'b1;
        end
        total++;
        if (stray !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_no_ready: got a ready after reset, required none");
        end
        run_txn(0, 32'h0000_0020, 32'd0, 4'd0, 32'h0000_0000, 1'b0, 1'b0, "mid_readback");
        idle(0, "mid_readback");
    endtask

    initial begin
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            din[d]        = '0;
            last_ready[d] = 0;
            held[d]       = 32'd0;
            held_ok[d]    = 1'b0;
        end
        test_reset();
        test_write_read();
        test_byte_lane();
        test_out_of_range();
        test_back_to_back();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
